// File: rtl/fir_result_byte_tx.sv
// fir_result_byte_tx
// Transmit side of the FIR pin interface. 32-bit (DATA_W) results from the FIR
// core are queued in a small word FIFO and sent out one byte per valid/ready
// handshake on the 8-bit dedicated outputs.
//
// Handshake: a byte moves on a rising edge where tx_vld & tx_rdy. While tx_vld
// is high, tx_byte/tx_idx/tx_last hold until that edge. tx_rdy is ignored while
// tx_vld is low. The word being sent stays at the FIFO head until its last byte
// moves; that edge pops it.
module fir_result_byte_tx #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int MSB_FIRST  = 0,
  localparam int NB        = DATA_W / 8,
  localparam int IW        = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] y_dat,
  input  logic              y_vld,
  input  logic              clr_ovf,
  output logic [7:0]        tx_byte,
  output logic              tx_vld,
  input  logic              tx_rdy,
  output logic              tx_last,
  output logic [IW-1:0]     tx_idx,
  output logic              fifo_full,
  output logic              ovf
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t state, state_d;

  // Word storage and pointers; depth is a power of two so pointers wrap freely.
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     rd_ptr_nx;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_d;

  // Transfer qualifiers for the current cycle.
  logic hs;
  logic last_hs;
  logic full_now;
  logic push_ok;
  logic drop;

  // Next-cycle presentation, produced by the next-state logic.
  logic [IW-1:0]     idx_d;
  logic              load;
  logic [DATA_W-1:0] next_word;

  // Next values of the registered outputs.
  logic [7:0] byte_d;
  logic       vld_d;
  logic       last_d;

  // Pick byte k (send order) out of a word.
  function automatic logic [7:0] sel_byte(input logic [DATA_W-1:0] w,
                                          input logic [IW-1:0]     k);
    logic [DATA_W-1:0] sh;
    if (MSB_FIRST != 0) sh = w >> (DATA_W - 8 - 8 * int'(k));
    else                sh = w >> (8 * int'(k));
    return sh[7:0];
  endfunction

  // Handshake, pop and push/drop decisions for this cycle.
  always_comb begin
    hs        = (state == SEND) & tx_rdy;
    last_hs   = hs & (tx_idx == LAST_IDX);
    full_now  = (count == DEPTH_C);
    push_ok   = y_vld & (~full_now | last_hs);
    drop      = y_vld & full_now & ~last_hs;
    rd_ptr_nx = rd_ptr + PW'(1);
  end

  // Occupancy after this cycle's push and pop.
  always_comb begin
    count_d = count;
    if (push_ok & ~last_hs)      count_d = count + CW'(1);
    else if (~push_ok & last_hs) count_d = count - CW'(1);
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      fifo_full <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (last_hs) rd_ptr <= rd_ptr_nx;
      count     <= count_d;
      fifo_full <= (count_d == DEPTH_C);
    end
  end

  // Word storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= y_dat;
  end

  // Sticky overflow flag; a drop in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (clr_ovf) ovf <= 1'b0;
  end

  // FSM state register together with the registered byte outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tx_idx  <= '0;
      tx_byte <= '0;
      tx_vld  <= 1'b0;
      tx_last <= 1'b0;
    end else begin
      state   <= state_d;
      tx_idx  <= idx_d;
      tx_byte <= byte_d;
      tx_vld  <= vld_d;
      tx_last <= last_d;
    end
  end

  // Next state, next byte index and the word to present next cycle.
  // A word pushed into an empty FIFO is taken straight from y_dat.
  always_comb begin
    state_d   = state;
    idx_d     = tx_idx;
    load      = 1'b0;
    next_word = mem[rd_ptr];
    case (state)
      IDLE: begin
        if (count != '0) begin
          state_d   = SEND;
          idx_d     = '0;
          load      = 1'b1;
          next_word = mem[rd_ptr];
        end else if (push_ok) begin
          state_d   = SEND;
          idx_d     = '0;
          load      = 1'b1;
          next_word = y_dat;
        end
      end
      SEND: begin
        if (hs) begin
          if (tx_idx != LAST_IDX) begin
            idx_d     = tx_idx + IW'(1);
            load      = 1'b1;
            next_word = mem[rd_ptr];
          end else if (count_d != '0) begin
            // Next word follows with no bubble: the one behind the head if
            // there is one, otherwise the word pushed on this same edge.
            idx_d     = '0;
            load      = 1'b1;
            next_word = (count > CW'(1)) ? mem[rd_ptr_nx] : y_dat;
          end else begin
            state_d = IDLE;
            idx_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Output values for the next cycle: hold while stalled, zero when idle.
  always_comb begin
    byte_d = tx_byte;
    vld_d  = (state_d == SEND);
    last_d = vld_d & (idx_d == LAST_IDX);
    if (state_d != SEND) byte_d = '0;
    else if (load)       byte_d = sel_byte(next_word, idx_d);
  end

endmodule
